// File: rtl/dtree_datapath_if.sv
// Handshake and strobe bundle between the spike-classification controller
// (master) and the feature/accumulator datapath (slave).
interface dtree_datapath_if #(
  parameter int FEATURE_BIT_DEPTH = 8,
  parameter int COEFF_BIT_DEPTH   = 4,
  parameter int BIAS_BIT_DEPTH    = 10
);
  logic signed [FEATURE_BIT_DEPTH-1:0] feature_in;
  logic                                feature_valid;
  logic                                feature_ready;
  logic                                next;
  logic                                classify_done;
  logic                                load_bias;
  logic                                add;
  logic                                mult;
  logic                                is_one;
  logic signed [COEFF_BIT_DEPTH-1:0]   coeff;
  logic signed [BIAS_BIT_DEPTH-1:0]    bias;
  logic                                child_direction;

  modport master (
    output feature_in, feature_valid, classify_done,
           load_bias, add, mult, is_one, coeff, bias,
    input  feature_ready, next, child_direction
  );

  modport slave (
    input  feature_in, feature_valid, classify_done,
           load_bias, add, mult, is_one, coeff, bias,
    output feature_ready, next, child_direction
  );
endinterface

// File: rtl/dtree_datapath.sv
// Ping-pong feature buffer plus signed linear-decision accumulator for the spike tree.
// Optional: define DTREE_DP_SATURATE_EN to saturate the accumulator instead of wrapping.
module dtree_datapath #(
  parameter int FEATURES          = 3,
  parameter int FEATURE_BIT_DEPTH = 8,
  parameter int COEFF_BIT_DEPTH   = 4,
  parameter int BIAS_BIT_DEPTH    = 10,
  parameter int ACC_WIDTH         = 16
) (
  input  logic           clk,
  input  logic           reset,
  dtree_datapath_if.slave dp
);
  localparam int IDX_W  = (FEATURES > 1) ? $clog2(FEATURES) : 1;
  localparam int PROD_W = FEATURE_BIT_DEPTH + COEFF_BIT_DEPTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEATURES - 1);

  typedef enum logic {FILL, FULL} ingress_t;
  typedef enum logic {IDLE, BUSY} active_t;

  ingress_t ing_state, ing_next;
  active_t  act_state, act_next;

  logic signed [FEATURE_BIT_DEPTH-1:0] bank [2][FEATURES];
  logic                                fill_sel;
  logic [IDX_W-1:0]                    wr_idx, k, rd_idx, k_next;
  logic                                next_q;
  logic                                accept, last_accept, swap;

  logic signed [FEATURE_BIT_DEPTH-1:0] feat;
  logic signed [PROD_W-1:0]            prod;
  logic signed [ACC_WIDTH-1:0]         acc, acc_next, term, base;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    accept      = dp.feature_valid && dp.feature_ready;
    last_accept = accept && (wr_idx == LAST_IDX);
    // The last sample can hand straight over to an idle active bank, giving next at t+1.
    swap        = (act_state == IDLE) && ((ing_state == FULL) || last_accept);

    ing_next = ing_state;
    case (ing_state)
      FILL: if (last_accept && !swap) ing_next = FULL;
      FULL: if (swap)                 ing_next = FILL;
    endcase

    act_next = act_state;
    case (act_state)
      IDLE: if (swap)             act_next = BUSY;
      BUSY: if (dp.classify_done) act_next = IDLE;
    endcase
  end

  always_comb begin
    rd_idx = dp.load_bias ? '0 : k;
    k_next = (rd_idx == LAST_IDX) ? '0 : rd_idx + IDX_W'(1);
    feat   = bank[~fill_sel][rd_idx];
    prod   = PROD_W'(dp.coeff) * PROD_W'(feat);

    term = '0;
    if (dp.is_one)    term = ACC_WIDTH'(feat);
    else if (dp.mult) term = ACC_WIDTH'(prod);

    base = dp.load_bias ? ACC_WIDTH'(dp.bias) : acc;
  end

`ifdef DTREE_DP_SATURATE_EN
  localparam int SUM_W = ACC_WIDTH + 1;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic signed [SUM_W-1:0] sum;

  // One guard bit exposes overflow: the top two bits disagree exactly when it occurred.
  always_comb begin
    sum = SUM_W'(base) + SUM_W'(term);
    if (sum[SUM_W-1] != sum[SUM_W-2]) acc_next = sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
    else                              acc_next = sum[ACC_WIDTH-1:0];
  end
`else
  always_comb acc_next = base + term;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ing_state <= FILL;
      act_state <= IDLE;
      wr_idx    <= '0;
      fill_sel  <= 1'b0;
      next_q    <= 1'b0;
      acc       <= '0;
      k         <= '0;
      // NOTE: the banks are cleared on reset so strobes against an idle bank read zeros.
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < FEATURES; i++)
          bank[b][i] <= '0;
    end else begin
      ing_state <= ing_next;
      act_state <= act_next;
      next_q    <= swap;
      if (accept) begin
        bank[fill_sel][wr_idx] <= dp.feature_in;
        wr_idx <= last_accept ? '0 : wr_idx + IDX_W'(1);
      end
      if (swap) fill_sel <= ~fill_sel;
      if (dp.add) begin
        acc <= acc_next;
        k   <= k_next;
      end
    end
  end

  assign dp.feature_ready   = reset && (ing_state == FILL);
  assign dp.next            = next_q;
  assign dp.child_direction = acc[ACC_WIDTH-1];
endmodule
